// File: rtl/wb_queue.sv
// Write-back queue: in-order FIFO between the mem/ex result sources and the register file write port.
// Define WBQ_FWD_EN to forward the youngest pending value for each decode read port.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_wn,
  input  logic [31:0]                mem_d,
  output logic                       mem_ready,
  input  logic                       ex_valid,
  input  logic [4:0]                 ex_wn,
  input  logic [31:0]                ex_d,
  output logic                       ex_ready,
  input  logic                       wb_stall,
  output logic                       we,
  output logic [4:0]                 wn,
  output logic [31:0]                d,
  input  logic [4:0]                 rna,
  input  logic [4:0]                 rnb,
  output logic                       pend_a,
  output logic                       pend_b,
  output logic [31:0]                fwd_a,
  output logic [31:0]                fwd_b,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [4:0]    wn_mem [DEPTH];
  logic [31:0]   d_mem  [DEPTH];

  logic          not_full, empty, enq, deq;
  logic [4:0]    enq_wn;
  logic [31:0]   enq_d;
  logic [DEPTH-1:0] hit_a, hit_b;

  assign not_full  = count_reg < FULL;
  assign empty     = (count_reg == '0);
  assign mem_ready = not_full;
  assign ex_ready  = not_full && !mem_valid;

  // Register 0 writes complete the handshake but are dropped here.
  assign enq    = (mem_valid && not_full && (mem_wn != 5'd0)) ||
                  (ex_valid && ex_ready && (ex_wn != 5'd0));
  assign enq_wn = mem_valid ? mem_wn : ex_wn;
  assign enq_d  = mem_valid ? mem_d : ex_d;

  assign deq   = !empty && !wb_stall;
  assign we    = deq;
  assign wn    = empty ? 5'd0 : wn_mem[head_reg];
  assign d     = empty ? 32'd0 : d_mem[head_reg];
  assign count = count_reg;

  // An entry is occupied when its distance from head is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
      logic [AW-1:0] off;
      logic          occ;
      assign off       = AW'(gi) - head_reg;
      assign occ       = {1'b0, off} < count_reg;
      assign hit_a[gi] = occ && (wn_mem[gi] == rna);
      assign hit_b[gi] = occ && (wn_mem[gi] == rnb);
    end
  endgenerate

  assign pend_a = (rna != 5'd0) && (|hit_a);
  assign pend_b = (rnb != 5'd0) && (|hit_b);

`ifdef WBQ_FWD_EN
  logic [AW-1:0] fwd_idx;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_a   = '0;
    fwd_b   = '0;
    fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_reg + AW'(k);
      if (pend_a && hit_a[fwd_idx]) fwd_a = d_mem[fwd_idx];
      if (pend_b && hit_b[fwd_idx]) fwd_b = d_mem[fwd_idx];
    end
  end
`else
  assign fwd_a = '0;
  assign fwd_b = '0;
`endif

  always_comb begin
    head_next  = deq ? head_reg + AW'(1) : head_reg;
    tail_next  = enq ? tail_reg + AW'(1) : tail_reg;
    count_next = count_reg;
    if (enq && !deq)      count_next = count_reg + CW'(1);
    else if (!enq && deq) count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wn_mem[i] <= '0;
        d_mem[i]  <= '0;
      end
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      if (enq) begin
        wn_mem[tail_reg] <= enq_wn;
        d_mem[tail_reg]  <= enq_d;
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Randomized scoreboard bench for wb_queue; a queue-based reference model predicts handshakes,
// occupancy and pending/forward results while a monitor checks each register file write in order.
module tb_wb_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mem_valid, ex_valid, wb_stall;
  logic [4:0]  mem_wn, ex_wn, rna, rnb;
  logic [31:0] mem_d, ex_d;
  logic        mem_ready, ex_ready, we, pend_a, pend_b;
  logic [4:0]  wn;
  logic [31:0] d, fwd_a, fwd_b;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] d;
  } ent_t;

  ent_t mdl[$];
  ent_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn),
    .mem_valid(mem_valid), .mem_wn(mem_wn), .mem_d(mem_d), .mem_ready(mem_ready),
    .ex_valid(ex_valid), .ex_wn(ex_wn), .ex_d(ex_d), .ex_ready(ex_ready),
    .wb_stall(wb_stall), .we(we), .wn(wn), .d(d),
    .rna(rna), .rnb(rnb), .pend_a(pend_a), .pend_b(pend_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pend_of(input logic [4:0] rn);
    if (rn == 5'd0) return 1'b0;
    foreach (mdl[i]) if (mdl[i].wn == rn) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] fwd_of(input logic [4:0] rn);
`ifdef WBQ_FWD_EN
    if (rn == 5'd0) return 32'd0;
    for (int i = mdl.size() - 1; i >= 0; i--) if (mdl[i].wn == rn) return mdl[i].d;
`endif
    return 32'd0;
  endfunction

  // Monitor: every register file write must match the oldest expected entry.
  always @(negedge clk) begin : mon
    ent_t e;
    if (clrn === 1'b1 && we === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got write wn=%0d d=0x%08h required none", wn, d);
      end else begin
        e = sb.pop_front();
        chk("wb_wn", 32'(wn), 32'(e.wn));
        chk("wb_d", d, e.d);
      end
    end
  end

  // One cycle: drive, check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit mv, input logic [4:0] mw, input logic [31:0] md,
                      input bit ev, input logic [4:0] ew, input logic [31:0] ed, input bit st);
    bit full, drain;
    mem_valid = mv; mem_wn = mw; mem_d = md;
    ex_valid  = ev; ex_wn  = ew; ex_d  = ed;
    wb_stall  = st;
    @(negedge clk);
    full  = (mdl.size() >= DEPTH);
    drain = (mdl.size() > 0) && !st;
    chk("count", 32'(count), 32'(mdl.size()));
    chk("mem_ready", 32'(mem_ready), 32'(!full));
    chk("ex_ready", 32'(ex_ready), 32'(!full && !mv));
    chk("we", 32'(we), 32'(drain));
    if (mdl.size() == 0) begin
      chk("wn_empty", 32'(wn), 32'd0);
      chk("d_empty", d, 32'd0);
    end
    chk("pend_a", 32'(pend_a), 32'(pend_of(rna)));
    chk("pend_b", 32'(pend_b), 32'(pend_of(rnb)));
    chk("fwd_a", fwd_a, fwd_of(rna));
    chk("fwd_b", fwd_b, fwd_of(rnb));
    @(posedge clk);
    if (drain) void'(mdl.pop_front());
    if (!full) begin
      if (mv) begin
        $display("xfer mem wn=%0d d=0x%08h", mw, md);
        if (mw != 5'd0) begin mdl.push_back({mw, md}); sb.push_back({mw, md}); end
      end else if (ev) begin
        $display("xfer ex  wn=%0d d=0x%08h", ew, ed);
        if (ew != 5'd0) begin mdl.push_back({ew, ed}); sb.push_back({ew, ed}); end
      end
    end
    #1;
  endtask

  task automatic idle(input bit st);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, st);
  endtask

  task automatic check_reset_outputs();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wn", 32'(wn), 32'd0);
    chk("rst_d", d, 32'd0);
    chk("rst_pend_a", 32'(pend_a), 32'd0);
    chk("rst_pend_b", 32'(pend_b), 32'd0);
    chk("rst_fwd_a", fwd_a, 32'd0);
    chk("rst_fwd_b", fwd_b, 32'd0);
  endtask

  // Called just after a rising edge; reset is asserted and released away from clock edges.
  task automatic mid_reset();
    mem_valid = 1'b0; ex_valid = 1'b0; wb_stall = 1'b0;
    #2 clrn = 1'b0;
    #1 check_reset_outputs();
    mdl.delete();
    sb.delete();
    #4 clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    mem_valid = 1'b0; mem_wn = '0; mem_d = '0;
    ex_valid = 1'b0; ex_wn = '0; ex_d = '0;
    wb_stall = 1'b0; rna = '0; rnb = '0;
    #3 check_reset_outputs();
    #10 clrn = 1'b1;
    @(posedge clk);
    #1;

    // single write, minimum latency
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345678, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // mem wins over ex; ex holds valid until accepted
    step(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'h00005555, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h00005555, 1'b0);
    repeat (3) idle(1'b0);

    // fill under stall, blocked fifth, then drain and refill across the wrap
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(i * 256), 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hA0, 1'b1);
    repeat (5) idle(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), $urandom, 1'b1);
    repeat (4) idle(1'b0);

    // register 0 is dropped
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    repeat (2) idle(1'b0);

    // pending and youngest forwarding
    rna = 5'd7; rnb = 5'd0;
    step(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b1);
    chk("dir_pend_a", 32'(pend_a), 32'd1);
    chk("dir_pend_b", 32'(pend_b), 32'd0);
`ifdef WBQ_FWD_EN
    chk("dir_fwd_a", fwd_a, 32'h22);
`else
    chk("dir_fwd_a", fwd_a, 32'd0);
`endif
    repeat (3) idle(1'b0);

    // simultaneous enqueue and drain at occupancy two
    step(1'b1, 5'd12, $urandom, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd13, $urandom, 1'b0, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      rna = 5'($urandom_range(0, 31)); rnb = 5'($urandom_range(0, 31));
      step(1'b1, 5'($urandom_range(1, 31)), $urandom, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom, 1'b0);
    end
    chk("steady_count", 32'(count), 32'd2);

    // random traffic with a reset in the middle
    for (int i = 0; i < 300; i++) begin
      rna = 5'($urandom_range(0, 7)); rnb = 5'($urandom_range(0, 7));
      step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 3);
      if (i == 150) mid_reset();
    end

    repeat (DEPTH + 2) idle(1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
